// File: rtl/vp_mem_pkg.sv
// Shared definitions for the vector pipeline memory path: vector geometry,
// opcode encodings, responder state type and the word-to-beat index helper.
package vp_mem_pkg;

    // Vector word width and word-address width seen by the MEM stage
    localparam int VEC_W  = 192;
    localparam int ADDR_W = 21;

    // Width of the word-to-beat index arithmetic (addr*3 + beat)
    localparam int IDX_W  = 23;

    // Request opcodes; anything else is reported as an error
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;

    // Responder states: idle, reading beats, writing beats, holding a response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } mem_state_t;

    // Backing RAM index of a beat: addr*3 + beat, done as shift+add in 23 bits
    function automatic logic [IDX_W-1:0] ram_index(
        input logic [ADDR_W-1:0] addr,
        input logic [1:0]        beat
    );
        logic [IDX_W-1:0] a_ext;
        a_ext     = {2'b00, addr};
        ram_index = (a_ext << 1) + a_ext + {{(IDX_W-2){1'b0}}, beat};
    endfunction

    // True when the opcode is one the responder executes
    function automatic logic op_is_legal(input logic [2:0] op);
        op_is_legal = (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/sp_ram_sync.sv
// Single-port synchronous RAM: one address for read and write, registered
// read data (one cycle latency).
module sp_ram_sync #(
    parameter int    WIDTH     = 64,
    parameter int    DEPTH     = 303,
    parameter int    AW        = 9,
    parameter string INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    // Enabled access: write on we, registered read of the addressed word
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_reg[addr] <= wdata;
            end
            rdata_reg <= mem_reg[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/vec_data_mem.sv
// MEM-stage data memory responder: takes one 192-bit load/store request,
// walks it as three 64-bit beats over a single-port RAM, then presents a
// held response on a valid/ready channel.
module vec_data_mem
    import vp_mem_pkg::*;
#(
    parameter int    DEPTH     = 101,
    parameter int    BEAT_W    = 64,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [VEC_W-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [VEC_W-1:0]  rsp_rdata,
    output logic              rsp_err
);

    localparam int N_BEATS   = VEC_W / BEAT_W;
    localparam int RAM_DEPTH = N_BEATS * DEPTH;
    localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int LO_W      = VEC_W - BEAT_W;

    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [1:0]        LAST_BEAT = 2'(N_BEATS - 1);
    localparam logic [1:0]        DRAIN     = 2'(N_BEATS);

    // Control and response state
    mem_state_t        state_reg;
    logic [1:0]        ctr_reg;
    logic              err_pend_reg;
    logic              req_ready_reg;
    logic              rsp_valid_reg;
    logic              rsp_err_reg;
    logic [VEC_W-1:0]  rsp_rdata_reg;

    // Captured request and load assembly buffer
    logic [ADDR_W-1:0] addr_reg;
    logic [VEC_W-1:0]  wdata_reg;
    logic [VEC_W-1:0]  acc_reg;

    // RAM port
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [BEAT_W-1:0] ram_wdata;
    logic [BEAT_W-1:0] ram_rdata;

    // Request acceptance and error classification of the incoming request
    logic              accept;
    logic              req_bad;

    // Store data split into beats; slot 3 is a zero filler so the beat
    // counter can index the array over its full range
    logic [BEAT_W-1:0] wbeat [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wbeat
            if (gi < N_BEATS) begin : g_live
                assign wbeat[gi] = wdata_reg[gi*BEAT_W +: BEAT_W];
            end else begin : g_fill
                assign wbeat[gi] = '0;
            end
        end
    endgenerate

    assign accept  = req_valid && req_ready_reg && (state_reg == IDLE);
    assign req_bad = (req_addr >= DEPTH_A) || !op_is_legal(req_op);

    // RAM access: reads for beats 0..2 in RD, writes in WR, nothing on error
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = wbeat[ctr_reg];
        ram_addr  = RAM_AW'(ram_index(addr_reg, ctr_reg));
        if (!err_pend_reg) begin
            if (state_reg == RD && ctr_reg != DRAIN) begin
                ram_en = 1'b1;
            end else if (state_reg == WR) begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
        end
    end

    sp_ram_sync #(
        .WIDTH     (BEAT_W),
        .DEPTH     (RAM_DEPTH),
        .AW        (RAM_AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Request capture, beat sequencing and response register in one FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ctr_reg       <= 2'd0;
            err_pend_reg  <= 1'b0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (accept) begin
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        acc_reg       <= '0;
                        ctr_reg       <= 2'd0;
                        err_pend_reg  <= req_bad;
                        req_ready_reg <= 1'b0;
                        // Illegal requests park in RD for one cycle, then report
                        state_reg     <= (req_op == OP_STORE && !req_bad) ? WR : RD;
                    end
                end

                RD: begin
                    if (err_pend_reg) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_rdata_reg <= '0;
                    end else if (ctr_reg == DRAIN) begin
                        // Last beat arrives straight from the RAM output
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b0;
                        rsp_rdata_reg <= {ram_rdata, acc_reg[LO_W-1:0]};
                    end else begin
                        // Data for the previous beat's read is now valid
                        if (ctr_reg != 2'd0) begin
                            acc_reg[(ctr_reg - 2'd1)*BEAT_W +: BEAT_W] <= ram_rdata;
                        end
                        ctr_reg <= ctr_reg + 2'd1;
                    end
                end

                WR: begin
                    if (err_pend_reg) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_rdata_reg <= '0;
                    end else if (ctr_reg == LAST_BEAT) begin
                        // Final beat commits this edge, so the store is
                        // fully visible before its response is seen
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b0;
                        rsp_rdata_reg <= '0;
                    end else begin
                        ctr_reg <= ctr_reg + 2'd1;
                    end
                end

                RESP: begin
                    // Hold everything until the consumer takes the response
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_vec_data_mem.sv
// Directed bench for vec_data_mem: stores, loads, error responses,
// back-pressure, top-of-memory boundary and reset during a load.
module tb_vec_data_mem;
    import vp_mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [VEC_W-1:0]  req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [VEC_W-1:0]  rsp_rdata;
    logic              rsp_err;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [VEC_W-1:0] DATA_ABC  = {64'hC, 64'hB, 64'hA};
    localparam logic [VEC_W-1:0] DATA_ZERO = {64'h0123_4567_89AB_CDEF,
                                              64'h1111_2222_3333_4444,
                                              64'hDEAD_BEEF_CAFE_F00D};
    localparam logic [VEC_W-1:0] ONES      = {VEC_W{1'b1}};

    always #5 clk = ~clk;

    vec_data_mem #(
        .DEPTH     (101),
        .BEAT_W    (64),
        .INIT_FILE ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // Single comparison point: counts every vector, reports any miscompare
    task automatic chk(input string tag, input logic [VEC_W-1:0] got,
                       input logic [VEC_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full request/response transaction, driven and sampled on negedges
    task automatic do_req(input string name, input logic [2:0] op,
                          input logic [ADDR_W-1:0] addr, input logic [VEC_W-1:0] wd,
                          input int exp_lat, input logic exp_err,
                          input logic [VEC_W-1:0] exp_rd, input int bp);
        int lat;
        int wait_n;
        wait_n = 0;
        while (req_ready !== 1'b1 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        chk({name, " req_ready before"}, VEC_W'(req_ready), VEC_W'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        // Scramble request inputs; they must be ignored after acceptance
        req_valid = 1'b0;
        req_op    = ~op;
        req_addr  = ~addr;
        req_wdata = ~wd;
        lat = 1;
        chk({name, " req_ready busy"}, VEC_W'(req_ready), VEC_W'(0));
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, VEC_W'(lat), VEC_W'(exp_lat));
        chk({name, " rsp_err"}, VEC_W'(rsp_err), VEC_W'(exp_err));
        chk({name, " rsp_rdata"}, rsp_rdata, exp_rd);
        if (bp > 0) begin
            // Competing request offered while the response is stalled
            req_valid = 1'b1;
            req_op    = OP_STORE;
            req_addr  = 21'd0;
            req_wdata = '0;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk({name, " bp rsp_valid"}, VEC_W'(rsp_valid), VEC_W'(1));
                chk({name, " bp rsp_rdata"}, rsp_rdata, exp_rd);
                chk({name, " bp rsp_err"}, VEC_W'(rsp_err), VEC_W'(exp_err));
                chk({name, " bp req_ready"}, VEC_W'(req_ready), VEC_W'(0));
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, " rsp_valid after"}, VEC_W'(rsp_valid), VEC_W'(0));
        chk({name, " req_ready after"}, VEC_W'(req_ready), VEC_W'(1));
        $display("txn %-12s op=%0d addr=%0d lat=%0d err=%0b rdata=%h",
                 name, op, addr, lat, exp_err, exp_rd);
    endtask

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_LOAD;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset req_ready", VEC_W'(req_ready), VEC_W'(0));
        chk("reset rsp_valid", VEC_W'(rsp_valid), VEC_W'(0));
        chk("reset rsp_rdata", rsp_rdata, '0);
        chk("reset rsp_err", VEC_W'(rsp_err), VEC_W'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", VEC_W'(req_ready), VEC_W'(1));

        do_req("st_a0",    OP_STORE, 21'd0,   DATA_ZERO, 4, 1'b0, '0, 0);
        do_req("st_a5",    OP_STORE, 21'd5,   DATA_ABC,  4, 1'b0, '0, 0);
        do_req("ld_a5_bp", OP_LOAD,  21'd5,   '0,        5, 1'b0, DATA_ABC, 7);
        do_req("ld_a101",  OP_LOAD,  21'd101, '0,        2, 1'b1, '0, 0);
        do_req("op7_a5",   3'b111,   21'd5,   ONES,      2, 1'b1, '0, 0);
        do_req("st_a101",  OP_STORE, 21'd101, ONES,      2, 1'b1, '0, 0);
        do_req("ld_a5_chk",OP_LOAD,  21'd5,   '0,        5, 1'b0, DATA_ABC, 0);
        do_req("st_a100",  OP_STORE, 21'd100, ONES,      4, 1'b0, '0, 0);
        do_req("ld_a100",  OP_LOAD,  21'd100, '0,        5, 1'b0, ONES, 0);
        do_req("ld_a0",    OP_LOAD,  21'd0,   '0,        5, 1'b0, DATA_ZERO, 0);

        // Reset two cycles into a load: no response, ready one cycle after release
        req_valid = 1'b1;
        req_op    = OP_LOAD;
        req_addr  = 21'd5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midrst rsp_valid", VEC_W'(rsp_valid), VEC_W'(0));
            chk("midrst req_ready", VEC_W'(req_ready), VEC_W'(0));
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("postrst rsp_valid", VEC_W'(rsp_valid), VEC_W'(0));
            if (i == 0) chk("postrst req_ready", VEC_W'(req_ready), VEC_W'(1));
        end
        $display("txn %-12s aborted load addr=5 by reset", "rst_mid_ld");

        do_req("ld_a5_rst", OP_LOAD, 21'd5, '0, 5, 1'b0, DATA_ABC, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
